physics_scheduler: RTL

Sequences the per-frame update of the N-entity box/dog physics datapath through a single shared operation port. The game core loop no longer updates every entity in one cycle. Each frame_tick starts a fixed schedule:
- MOVE: friction, position and wall bounce, one op per entity.
- POWER: power-up evaluation, one op per entity.
- PAIR: overlap and collision, one op per unordered pair (a<b).

Every op uses a valid/ready handshake. The block sits between vga_timing's frame_tick and the physics datapath, and it reports frame completion and dropped frames.

---
 rtl/physics_scheduler_if.sv | 27 ++
 rtl/physics_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/physics_scheduler_if.sv
// Op port between the physics scheduler and the physics datapath.
// Valid/ready handshake carrying an op code and up to two entity indices.
interface physics_scheduler_if #(
    parameter int unsigned IDX_W = 3
) ();
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [IDX_W-1:0] op_a;
    logic [IDX_W-1:0] op_b;

    modport master (
        output op_valid,
        output op_code,
        output op_a,
        output op_b,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_a,
        input  op_b,
        output op_ready
    );
endinterface

// File: rtl/physics_scheduler.sv
// Per-frame op sequencer: MOVE and POWER per entity, then PAIR per unordered pair,
// issued one at a time over a shared valid/ready port. Counts frame ticks dropped while busy.
module physics_scheduler #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 enable,
    physics_scheduler_if.master  op,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           overrun_cnt
);
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_A     = IDX_W'(N - 2);
    localparam logic [1:0]       OP_MOVE    = 2'd0;
    localparam logic [1:0]       OP_POWER   = 2'd1;
    localparam logic [1:0]       OP_PAIR    = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        POWER = 3'd2,
        PAIR  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] b_q, b_d;

    logic             op_valid_d;
    logic [1:0]       op_code_d;
    logic [IDX_W-1:0] op_a_d;
    logic [IDX_W-1:0] op_b_d;
    logic             busy_d;
    logic             frame_done_d;
    logic             hs;

    assign hs = op.op_valid & op.op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state/indices, then outputs decoded from the next state so they register in step.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_valid_d   = 1'b0;
        op_code_d    = OP_MOVE;
        op_a_d       = '0;
        op_b_d       = '0;
        busy_d       = 1'b1;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_tick && enable) begin
                    state_d = MOVE;
                    a_d     = '0;
                    b_d     = '0;
                end
            end
            MOVE: begin
                if (hs) begin
                    if (a_q == LAST_IDX) begin
                        state_d = POWER;
                        a_d     = '0;
                    end else begin
                        a_d = a_q + IDX_W'(1);
                    end
                end
            end
            POWER: begin
                if (hs) begin
                    if (a_q == LAST_IDX) begin
                        state_d = PAIR;
                        a_d     = '0;
                        b_d     = IDX_W'(1);
                    end else begin
                        a_d = a_q + IDX_W'(1);
                    end
                end
            end
            PAIR: begin
                if (hs) begin
                    if (b_q != LAST_IDX) begin
                        b_d = b_q + IDX_W'(1);
                    end else if (a_q != LAST_A) begin
                        a_d = a_q + IDX_W'(1);
                        b_d = a_q + IDX_W'(2);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            MOVE: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_MOVE;
                op_a_d     = a_d;
            end
            POWER: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_POWER;
                op_a_d     = a_d;
            end
            PAIR: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_PAIR;
                op_a_d     = a_d;
                op_b_d     = b_d;
            end
            DONE:    frame_done_d = 1'b1;
            IDLE:    busy_d       = 1'b0;
            default: busy_d       = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op.op_valid <= 1'b0;
            op.op_code  <= OP_MOVE;
            op.op_a     <= '0;
            op.op_b     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            op.op_valid <= op_valid_d;
            op.op_code  <= op_code_d;
            op.op_a     <= op_a_d;
            op.op_b     <= op_b_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

    // Ticks arriving outside IDLE are dropped and counted, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
        end else if (frame_tick && (state_q != IDLE) && (overrun_cnt != CNT_MAX)) begin
            overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
    end
endmodule
